// File: rtl/pe_ctrl.sv
// Per-job sequencer for one PE datapath: loads weights and ifmaps, clears psums,
// runs the MAC loop, then accumulates with neighbour psums and drains.
module pe_ctrl #(
  parameter int IFMAP_ADDR_BITWIDTH = 4,
  parameter int WGHT_ADDR_BITWIDTH  = 7,
  parameter int PSUM_ADDR_BITWIDTH  = 3,
  parameter int PIPE_LAT            = 3
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [IFMAP_ADDR_BITWIDTH:0]   i_filt_size,
  input  logic [PSUM_ADDR_BITWIDTH:0]    i_num_filt,
  input  logic                           i_wght_valid,
  output logic                           o_wght_ready,
  input  logic                           i_ifmap_valid,
  output logic                           o_ifmap_ready,
  input  logic                           i_psum_in_valid,
  output logic                           o_psum_in_ready,
  output logic                           o_ifmap_we,
  output logic [IFMAP_ADDR_BITWIDTH-1:0] o_ifmap_wa,
  output logic [IFMAP_ADDR_BITWIDTH-1:0] o_ifmap_ra,
  output logic                           o_wght_we,
  output logic [WGHT_ADDR_BITWIDTH-1:0]  o_wght_wa,
  output logic [WGHT_ADDR_BITWIDTH-1:0]  o_wght_ra,
  output logic                           o_psum_we,
  output logic [PSUM_ADDR_BITWIDTH-1:0]  o_psum_wa,
  output logic [PSUM_ADDR_BITWIDTH-1:0]  o_psum_ra,
  output logic                           o_acc_sel,
  output logic                           o_rst_psum,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err
);
  localparam int IW = IFMAP_ADDR_BITWIDTH;
  localparam int WW = WGHT_ADDR_BITWIDTH;
  localparam int PW = PSUM_ADDR_BITWIDTH;
  localparam int XW = IW + PW + 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LD_W  = 3'd1;
  localparam logic [2:0] ST_LD_I  = 3'd2;
  localparam logic [2:0] ST_CLR   = 3'd3;
  localparam logic [2:0] ST_MAC   = 3'd4;
  localparam logic [2:0] ST_ACC   = 3'd5;
  localparam logic [2:0] ST_DRAIN = 3'd6;

  localparam logic [IW:0] S_MAX    = (IW+1)'(2**IW);
  localparam logic [PW:0] M_MAX    = (PW+1)'(2**PW);
  localparam logic [XW-1:0] SM_MAX = XW'(2**WW);
  localparam logic [PW:0] LAT_SLOT = (PW+1)'(PIPE_LAT);
  localparam logic [WW:0] LAT_LAST = (WW+1)'(PIPE_LAT - 1);

  logic [2:0]    state_q, state_d;
  logic [IW:0]   s_cfg_q, s_cfg_d, s_q, s_d;
  logic [PW:0]   m_cfg_q, m_cfg_d, slots_q, slots_d, j_q, j_d;
  logic [WW:0]   base_q, base_d, cnt_q, cnt_d;

  logic          wght_ready_q, wght_ready_d, ifmap_ready_q, ifmap_ready_d;
  logic          psum_in_ready_q, psum_in_ready_d;
  logic          ifmap_we_q, ifmap_we_d, wght_we_q, wght_we_d, psum_we_q, psum_we_d;
  logic [IW-1:0] ifmap_wa_q, ifmap_wa_d, ifmap_ra_q, ifmap_ra_d;
  logic [WW-1:0] wght_wa_q, wght_wa_d, wght_ra_q, wght_ra_d;
  logic [PW-1:0] psum_wa_q, psum_wa_d, psum_ra_q, psum_ra_d;
  logic          acc_sel_q, acc_sel_d, rst_psum_q, rst_psum_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic          wght_hs, ifmap_hs, psum_hs, legal;
  logic          s_last, jm_last, slot_last, cnt_s_last, cnt_m_last;
  logic [XW-1:0] prod;

  assign wght_hs    = i_wght_valid & wght_ready_q;
  assign ifmap_hs   = i_ifmap_valid & ifmap_ready_q;
  assign psum_hs    = i_psum_in_valid & psum_in_ready_q;
  assign prod       = {{(PW+1){1'b0}}, i_filt_size} * {{(IW+1){1'b0}}, i_num_filt};
  assign legal      = (i_filt_size != '0) && (i_filt_size <= S_MAX) &&
                      (i_num_filt != '0) && (i_num_filt <= M_MAX) && (prod <= SM_MAX);
  assign s_last     = (s_q == s_cfg_q - 1'b1);
  assign jm_last    = (j_q == m_cfg_q - 1'b1);
  assign slot_last  = (j_q == slots_q - 1'b1);
  assign cnt_s_last = (cnt_q == (WW+1)'(s_cfg_q) - 1'b1);
  assign cnt_m_last = (cnt_q == (WW+1)'(m_cfg_q) - 1'b1);

  // Next-state and loop counters; j*S for the weight read address is kept in base_q.
  always_comb begin
    state_d = state_q;
    s_cfg_d = s_cfg_q;
    m_cfg_d = m_cfg_q;
    slots_d = slots_q;
    s_d     = s_q;
    j_d     = j_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (legal) begin
            state_d = ST_LD_W;
            s_cfg_d = i_filt_size;
            m_cfg_d = i_num_filt;
            slots_d = (i_num_filt > LAT_SLOT) ? i_num_filt : LAT_SLOT;
            s_d     = '0;
            j_d     = '0;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LD_W: begin
        if (wght_hs) begin
          cnt_d = cnt_q + 1'b1;
          if (s_last) begin
            s_d = '0;
            if (jm_last) begin
              state_d = ST_LD_I;
              cnt_d   = '0;
              j_d     = '0;
            end else begin
              j_d = j_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_LD_I: begin
        if (ifmap_hs) begin
          if (cnt_s_last) begin
            state_d = ST_CLR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_CLR: begin
        if (cnt_m_last) begin
          state_d = ST_MAC;
          cnt_d   = '0;
          s_d     = '0;
          j_d     = '0;
          base_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_MAC: begin
        if (slot_last) begin
          j_d    = '0;
          base_d = '0;
          if (s_last) begin
            state_d = ST_ACC;
            cnt_d   = '0;
          end else begin
            s_d = s_q + 1'b1;
          end
        end else begin
          j_d    = j_q + 1'b1;
          base_d = base_q + (WW+1)'(s_cfg_q);
        end
      end
      ST_ACC: begin
        if (psum_hs) begin
          if (cnt_m_last) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == LAT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode. Stream writes and neighbour-accumulate issues land one cycle
  // after their handshake; CLR/MAC/DRAIN outputs are decoded from the next state.
  always_comb begin
    wght_ready_d    = (state_d == ST_LD_W);
    ifmap_ready_d   = (state_d == ST_LD_I);
    psum_in_ready_d = (state_d == ST_ACC);
    busy_d          = (state_d != ST_IDLE);
    done_d          = (state_d == ST_DRAIN) && (cnt_d == LAT_LAST);

    wght_we_d  = wght_hs;
    wght_wa_d  = wght_hs ? cnt_q[WW-1:0] : wght_wa_q;
    ifmap_we_d = ifmap_hs;
    ifmap_wa_d = ifmap_hs ? cnt_q[IW-1:0] : ifmap_wa_q;

    psum_we_d  = 1'b0;
    psum_wa_d  = psum_wa_q;
    psum_ra_d  = psum_ra_q;
    ifmap_ra_d = ifmap_ra_q;
    wght_ra_d  = wght_ra_q;
    rst_psum_d = 1'b0;
    acc_sel_d  = 1'b0;

    if (state_d == ST_CLR) begin
      rst_psum_d = 1'b1;
      psum_we_d  = 1'b1;
      psum_wa_d  = cnt_d[PW-1:0];
    end else if (state_d == ST_MAC && j_d < m_cfg_q) begin
      psum_we_d  = 1'b1;
      psum_wa_d  = j_d[PW-1:0];
      psum_ra_d  = j_d[PW-1:0];
      ifmap_ra_d = s_d[IW-1:0];
      wght_ra_d  = base_d[WW-1:0] + WW'(s_d);
    end

    if (psum_hs) begin
      acc_sel_d = 1'b1;
      psum_ra_d = cnt_q[PW-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      s_cfg_q         <= '0;
      m_cfg_q         <= '0;
      slots_q         <= '0;
      s_q             <= '0;
      j_q             <= '0;
      base_q          <= '0;
      cnt_q           <= '0;
      wght_ready_q    <= 1'b0;
      ifmap_ready_q   <= 1'b0;
      psum_in_ready_q <= 1'b0;
      ifmap_we_q      <= 1'b0;
      ifmap_wa_q      <= '0;
      ifmap_ra_q      <= '0;
      wght_we_q       <= 1'b0;
      wght_wa_q       <= '0;
      wght_ra_q       <= '0;
      psum_we_q       <= 1'b0;
      psum_wa_q       <= '0;
      psum_ra_q       <= '0;
      acc_sel_q       <= 1'b0;
      rst_psum_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      s_cfg_q         <= s_cfg_d;
      m_cfg_q         <= m_cfg_d;
      slots_q         <= slots_d;
      s_q             <= s_d;
      j_q             <= j_d;
      base_q          <= base_d;
      cnt_q           <= cnt_d;
      wght_ready_q    <= wght_ready_d;
      ifmap_ready_q   <= ifmap_ready_d;
      psum_in_ready_q <= psum_in_ready_d;
      ifmap_we_q      <= ifmap_we_d;
      ifmap_wa_q      <= ifmap_wa_d;
      ifmap_ra_q      <= ifmap_ra_d;
      wght_we_q       <= wght_we_d;
      wght_wa_q       <= wght_wa_d;
      wght_ra_q       <= wght_ra_d;
      psum_we_q       <= psum_we_d;
      psum_wa_q       <= psum_wa_d;
      psum_ra_q       <= psum_ra_d;
      acc_sel_q       <= acc_sel_d;
      rst_psum_q      <= rst_psum_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign o_wght_ready    = wght_ready_q;
  assign o_ifmap_ready   = ifmap_ready_q;
  assign o_psum_in_ready = psum_in_ready_q;
  assign o_ifmap_we      = ifmap_we_q;
  assign o_ifmap_wa      = ifmap_wa_q;
  assign o_ifmap_ra      = ifmap_ra_q;
  assign o_wght_we       = wght_we_q;
  assign o_wght_wa       = wght_wa_q;
  assign o_wght_ra       = wght_ra_q;
  assign o_psum_we       = psum_we_q;
  assign o_psum_wa       = psum_wa_q;
  assign o_psum_ra       = psum_ra_q;
  assign o_acc_sel       = acc_sel_q;
  assign o_rst_psum      = rst_psum_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_err           = err_q;
endmodule

// File: tb/tb_pe_ctrl.sv
// Directed bench for pe_ctrl: nominal jobs, small M, stalls, illegal configs,
// mid-job reset and ignored starts.
module tb_pe_ctrl;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [4:0] filt;
  logic [3:0] num;
  logic       wv, iv, pv;
  logic       wght_ready, ifmap_ready, psum_in_ready;
  logic       ifmap_we, wght_we, psum_we, acc_sel, rst_psum, busy, done, err;
  logic [3:0] ifmap_wa, ifmap_ra;
  logic [6:0] wght_wa, wght_ra;
  logic [2:0] psum_wa, psum_ra;

  pe_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_filt_size(filt), .i_num_filt(num),
    .i_wght_valid(wv), .o_wght_ready(wght_ready),
    .i_ifmap_valid(iv), .o_ifmap_ready(ifmap_ready),
    .i_psum_in_valid(pv), .o_psum_in_ready(psum_in_ready),
    .o_ifmap_we(ifmap_we), .o_ifmap_wa(ifmap_wa), .o_ifmap_ra(ifmap_ra),
    .o_wght_we(wght_we), .o_wght_wa(wght_wa), .o_wght_ra(wght_ra),
    .o_psum_we(psum_we), .o_psum_wa(psum_wa), .o_psum_ra(psum_ra),
    .o_acc_sel(acc_sel), .o_rst_psum(rst_psum), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  int busy_cyc, done_cnt, err_cnt, acc_cnt, ra_ne_wa, finished;
  int wq[$], iq[$], cq[$], mw[$], mi[$], mp[$], mcyc[$], aq[$];

  function automatic int all_outs();
    return int'({wght_ready, ifmap_ready, psum_in_ready, ifmap_we, ifmap_wa, ifmap_ra,
                 wght_we, wght_wa, wght_ra, psum_we, psum_wa, psum_ra,
                 acc_sel, rst_psum, busy, done, err} != '0);
  endfunction

  // Pulses start with the given config and records every output event until done.
  task automatic run_job(input int s, input int m, input bit wtog, input bit ptog,
                         input bit poke);
    busy_cyc = 0; done_cnt = 0; err_cnt = 0; acc_cnt = 0; ra_ne_wa = 0; finished = 0;
    wq.delete(); iq.delete(); cq.delete(); mw.delete(); mi.delete(); mp.delete();
    mcyc.delete(); aq.delete();
    filt = 5'(s); num = 4'(m); start = 1'b1; wv = 1'b1; iv = 1'b1; pv = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) busy_cyc++;
      if (wght_we) wq.push_back(int'(wght_wa));
      if (ifmap_we) iq.push_back(int'(ifmap_wa));
      if (rst_psum && psum_we) cq.push_back(int'(psum_wa));
      else if (psum_we) begin
        mw.push_back(int'(wght_ra)); mi.push_back(int'(ifmap_ra));
        mp.push_back(int'(psum_wa)); mcyc.push_back(cyc);
        if (psum_ra != psum_wa) ra_ne_wa++;
      end
      if (acc_sel) begin acc_cnt++; aq.push_back(int'(psum_ra)); end
      if (err) err_cnt++;
      if (done) done_cnt++;
      if (done_cnt > 0 && !busy) begin finished = 1; break; end
      if (wtog) wv = ~wv;
      if (ptog) pv = ~pv;
      if (poke && (ifmap_ready || psum_in_ready)) start = 1'b1;
    end
    start = 1'b0; wv = 1'b0; iv = 1'b0; pv = 1'b0;
    chk("job_finished", finished, 1);
  endtask

  // Expected sequences: weight/ifmap/clear addresses count up; MAC issue i is row i/m,
  // filter i%m, reading weight (i%m)*s + i/m.
  task automatic check_job(input string nm, input int s, input int m, input int exp_busy);
    int bad, gap_bad, last_seen[8];
    if (exp_busy >= 0) chk({nm, "_busy_cycles"}, busy_cyc, exp_busy);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_err_pulses"}, err_cnt, 0);
    chk({nm, "_wght_writes"}, wq.size(), s * m);
    bad = 0; foreach (wq[i]) if (wq[i] != i) bad++;
    chk({nm, "_wght_wa_seq"}, bad, 0);
    chk({nm, "_ifmap_writes"}, iq.size(), s);
    bad = 0; foreach (iq[i]) if (iq[i] != i) bad++;
    chk({nm, "_ifmap_wa_seq"}, bad, 0);
    chk({nm, "_clr_writes"}, cq.size(), m);
    bad = 0; foreach (cq[i]) if (cq[i] != i) bad++;
    chk({nm, "_clr_wa_seq"}, bad, 0);
    chk({nm, "_mac_issues"}, mw.size(), s * m);
    bad = 0;
    foreach (mw[i]) if (mw[i] != (i % m) * s + i / m || mi[i] != i / m || mp[i] != i % m) bad++;
    chk({nm, "_mac_addr_seq"}, bad, 0);
    chk({nm, "_mac_ra_eq_wa"}, ra_ne_wa, 0);
    gap_bad = 0;
    foreach (last_seen[k]) last_seen[k] = -100;
    foreach (mp[i]) begin
      if (mcyc[i] - last_seen[mp[i]] < 3) gap_bad++;
      last_seen[mp[i]] = mcyc[i];
    end
    chk({nm, "_psum_raw_gap"}, gap_bad, 0);
    chk({nm, "_acc_sel_count"}, acc_cnt, m);
    bad = 0; foreach (aq[i]) if (aq[i] != i) bad++;
    chk({nm, "_acc_ra_seq"}, bad, 0);
  endtask

  task automatic try_illegal(input string nm, input int s, input int m);
    filt = 5'(s); num = 4'(m); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_err"}, int'(err), 1);
    chk({nm, "_busy"}, int'(busy), 0);
    @(posedge clk); #1;
    chk({nm, "_err_one_cycle"}, int'(err), 0);
    chk({nm, "_still_idle"}, int'(busy), 0);
  endtask

  int wexp[12] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
  int found;

  initial begin
    rst = 1'b1; start = 1'b0; filt = '0; num = '0; wv = 1'b0; iv = 1'b0; pv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_zero", all_outs(), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // S=3, M=4: 12 LD_W + 3 LD_I + 4 CLR + 12 MAC + 4 ACC + 3 DRAIN busy cycles.
    run_job(3, 4, 1'b0, 1'b0, 1'b0);
    check_job("nominal", 3, 4, 38);
    foreach (wexp[i]) if (i < mw.size()) chk("nominal_wght_ra_table", mw[i], wexp[i]);

    // S=2, M=1: three-slot MAC rows, 2+2+1+6+1+3 busy cycles.
    run_job(2, 1, 1'b0, 1'b0, 1'b0);
    check_job("m1", 2, 1, 15);
    if (mcyc.size() == 2) chk("m1_issue_spacing", mcyc[1] - mcyc[0], 3);
    else chk("m1_issue_count", mcyc.size(), 2);

    run_job(3, 4, 1'b1, 1'b1, 1'b0);
    check_job("stall", 3, 4, -1);

    run_job(3, 4, 1'b0, 1'b0, 1'b1);
    check_job("start_ignored", 3, 4, 38);

    try_illegal("s0", 0, 4);
    try_illegal("m9", 3, 9);
    try_illegal("s17", 17, 1);

    // Exactly 128 weight entries is the largest legal job.
    run_job(16, 8, 1'b0, 1'b0, 1'b0);
    check_job("s16m8", 16, 8, 128 + 16 + 8 + 128 + 8 + 3);

    filt = 5'd3; num = 4'd4; start = 1'b1; wv = 1'b1; iv = 1'b1; pv = 1'b1;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (psum_we && !rst_psum) begin found = 1; break; end
    end
    chk("reach_mac_before_reset", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midjob_reset_outputs_zero", all_outs(), 0);
    @(posedge clk); #1;
    chk("after_reset_idle", int'(busy), 0);
    run_job(3, 4, 1'b0, 1'b0, 1'b0);
    check_job("post_reset", 3, 4, 38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
